k_round_sequencer: RTL and testbench

//  Sequences K-constant fetch for one SHA-256 block: issues K_LENGTH reads (address 0..K_LENGTH-1) to the K ROM.

---
 rtl/k_round_sequencer.sv | 137 +++++++++++++
 tb/tb_k_round_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k_round_sequencer.sv
// SHA-256 K-constant fetch sequencer: streams K ROM words to the round datapath
// through a small fall-through FIFO that hides ROM latency and round stalls.
module k_round_sequencer #(
    parameter int K_LENGTH    = 64,
    parameter int MEM_LATENCY = 1,
    parameter int BUF_DEPTH   = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        abort,
    output logic                        k_rd_en,
    output logic [$clog2(K_LENGTH)-1:0] k_address,
    input  logic [31:0]                 k_data,
    output logic                        round_valid,
    input  logic                        round_ready,
    output logic [31:0]                 round_k,
    output logic [$clog2(K_LENGTH)-1:0] round_index,
    output logic                        busy,
    output logic                        block_done
);

    localparam int AW = $clog2(K_LENGTH);
    localparam int CW = AW + 1;
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int NW = $clog2(BUF_DEPTH + 1);

    localparam logic [CW-1:0] K_C     = CW'(K_LENGTH);
    localparam logic [CW-1:0] K_LAST  = CW'(K_LENGTH - 1);
    localparam logic [NW:0]   DEPTH_C = (NW + 1)'(BUF_DEPTH);
    localparam logic [PW-1:0] P_LAST  = PW'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [CW-1:0]          issued;
    logic [CW-1:0]          accepted;
    logic [MEM_LATENCY-1:0] pend;
    logic [31:0]            mem [BUF_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [NW-1:0]          count;
    logic [NW:0]            inflight;
    logic [NW:0]            occupancy;
    logic                   matured;
    logic                   push;
    logic                   pop;
    logic                   clear;
    logic                   last_issue;
    logic                   last_accept;
    logic [31:0]            head;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == P_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + {{NW{1'b0}}, pend[i]};
        end
    end

    // Words still in flight count against the buffer, so a push never overflows.
    assign occupancy   = {1'b0, count} + inflight;
    assign matured     = pend[MEM_LATENCY-1];
    assign k_rd_en     = (state == RUN) && (issued < K_C) && (occupancy < DEPTH_C);
    assign k_address   = issued[AW-1:0];

    // An empty FIFO passes the maturing ROM word straight through.
    assign head        = (count == '0) ? k_data : mem[rd_ptr];
    assign round_valid = (count != '0) || matured;
    assign round_k     = round_valid ? head : '0;
    assign round_index = accepted[AW-1:0];
    assign busy        = (state != IDLE);
    assign block_done  = (state == DONE);

    assign push        = matured;
    assign pop         = round_valid && round_ready;
    assign last_issue  = k_rd_en && (issued == K_LAST);
    assign last_accept = pop && (accepted == K_LAST);

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:  if (start) state_nx = RUN;
                RUN:   if (last_issue) state_nx = DRAIN;
                DRAIN: if (last_accept) state_nx = DONE;
                DONE:  state_nx = IDLE;
            endcase
        end
    end

    assign clear = (state_nx == IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            issued   <= '0;
            accepted <= '0;
            pend     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_nx;
            if (clear) begin
                issued   <= '0;
                accepted <= '0;
                pend     <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                pend <= (pend << 1) | MEM_LATENCY'(k_rd_en);
                if (k_rd_en) issued <= issued + CW'(1);
                if (pop) accepted <= accepted + CW'(1);
                if (push) wr_ptr <= nxt(wr_ptr);
                if (pop) rd_ptr <= nxt(rd_ptr);
                if (push && !pop) begin
                    count <= count + NW'(1);
                end else if (pop && !push) begin
                    count <= count - NW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !clear) mem[wr_ptr] <= k_data;
    end

endmodule

// File: tb/tb_k_round_sequencer.sv
// Bench for k_round_sequencer: ML=1 and ML=3 instances share stimulus and are
// checked against a per-word availability model, a vector table and directed runs.
module tb_k_round_sequencer;

    localparam int K = 64;
    localparam int D = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n, start, abort, ready;
    logic rd1, rd3, rv1, rv3, busy1, busy3, done1, done3;
    logic [5:0] addr1, addr3, ri1, ri3;
    logic [31:0] kd1, kd3, rk1, rk3;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    k_round_sequencer #(.K_LENGTH(K), .MEM_LATENCY(1), .BUF_DEPTH(D)) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .k_rd_en(rd1), .k_address(addr1), .k_data(kd1),
        .round_valid(rv1), .round_ready(ready), .round_k(rk1),
        .round_index(ri1), .busy(busy1), .block_done(done1)
    );

    k_round_sequencer #(.K_LENGTH(K), .MEM_LATENCY(3), .BUF_DEPTH(D)) dut3 (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .k_rd_en(rd3), .k_address(addr3), .k_data(kd3),
        .round_valid(rv3), .round_ready(ready), .round_k(rk3),
        .round_index(ri3), .busy(busy3), .block_done(done3)
    );

    function automatic logic [31:0] word(input int i);
        return 32'h428a2f98 + i;
    endfunction

    // Pipelined ROMs; outside the valid slot they drive junk.
    logic        v1 = 1'b0;
    logic [31:0] d1 = '0;
    logic        v3 [3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] d3 [3] = '{32'h0, 32'h0, 32'h0};

    always @(posedge clock) begin
        v1 <= rd1;
        d1 <= word(int'(addr1));
        v3[0] <= rd3;
        d3[0] <= word(int'(addr3));
        v3[1] <= v3[0];
        d3[1] <= d3[0];
        v3[2] <= v3[1];
        d3[2] <= d3[1];
    end

    assign kd1 = v1 ? d1 : 32'hdead_beef;
    assign kd3 = v3[2] ? d3[2] : 32'hdead_beef;

    // Reference: each issued word becomes available ML cycles after its issue,
    // and words are accepted strictly in order.
    int ml  [2] = '{1, 3};
    int st  [2];
    int iss [2];
    int acc [2];
    int now [2];
    int rt  [2][K];

    int first_valid [2];
    int done_cyc    [2];
    int valid_cnt   [2];
    int rd_cnt      [2];
    bit done_seen   [2];

    function automatic bit m_rd(input int m);
        return st[m] == 1 && iss[m] < K && (iss[m] - acc[m]) < D;
    endfunction

    function automatic bit m_valid(input int m);
        return st[m] != 0 && acc[m] < iss[m] && rt[m][acc[m]] <= now[m];
    endfunction

    task automatic m_reset(input int m);
        st[m] = 0;
        iss[m] = 0;
        acc[m] = 0;
        now[m] = 0;
    endtask

    task automatic m_update(input int m, input bit s, input bit a, input bit r);
        bit rd, v;
        rd = m_rd(m);
        v = m_valid(m);
        if (a) begin
            st[m] = 0;
            iss[m] = 0;
            acc[m] = 0;
        end else if (st[m] == 0) begin
            if (s) st[m] = 1;
        end else if (st[m] == 1) begin
            if (rd) begin
                rt[m][iss[m]] = now[m] + ml[m];
                iss[m]++;
            end
            if (v && r) begin
                acc[m]++;
                if (acc[m] == K) st[m] = 2;
            end
        end else begin
            st[m] = 0;
            iss[m] = 0;
            acc[m] = 0;
        end
        now[m]++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr_track();
        for (int m = 0; m < 2; m++) begin
            first_valid[m] = -1;
            done_cyc[m] = -1;
            valid_cnt[m] = 0;
            rd_cnt[m] = 0;
            done_seen[m] = 1'b0;
        end
    endtask

    task automatic check_all();
        logic b, rd, v, d;
        logic [5:0] ad, ix;
        logic [31:0] k;
        bit ev;
        for (int m = 0; m < 2; m++) begin
            if (m == 0) begin
                b = busy1; rd = rd1; ad = addr1; v = rv1; ix = ri1; k = rk1; d = done1;
            end else begin
                b = busy3; rd = rd3; ad = addr3; v = rv3; ix = ri3; k = rk3; d = done3;
            end
            ev = m_valid(m);
            chk($sformatf("busy[ml%0d]", ml[m]), b, st[m] != 0);
            chk($sformatf("block_done[ml%0d]", ml[m]), d, st[m] == 2);
            chk($sformatf("k_rd_en[ml%0d]", ml[m]), rd, m_rd(m));
            chk($sformatf("k_address[ml%0d]", ml[m]), ad, iss[m] % K);
            chk($sformatf("round_valid[ml%0d]", ml[m]), v, ev);
            chk($sformatf("round_index[ml%0d]", ml[m]), ix, acc[m] % K);
            if (ev) chk($sformatf("round_k[ml%0d]", ml[m]), k, word(acc[m]));
            if (v && first_valid[m] < 0) first_valid[m] = cyc;
            if (v) valid_cnt[m]++;
            if (rd) rd_cnt[m]++;
            if (d) begin
                done_seen[m] = 1'b1;
                if (done_cyc[m] < 0) done_cyc[m] = cyc;
            end
        end
    endtask

    task automatic step(input bit s, input bit a, input bit r);
        start = s;
        abort = a;
        ready = r;
        #1;
        check_all();
        @(posedge clock);
        for (int m = 0; m < 2; m++) m_update(m, s, a, r);
        cyc++;
        @(negedge clock);
    endtask

    task automatic settle();
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_en"}, {rd3, rd1}, 0);
        chk({tag, "_addr"}, {addr3, addr1}, 0);
        chk({tag, "_valid"}, {rv3, rv1}, 0);
        chk({tag, "_k1"}, rk1, 0);
        chk({tag, "_k3"}, rk3, 0);
        chk({tag, "_index"}, {ri3, ri1}, 0);
        chk({tag, "_busy"}, {busy3, busy1}, 0);
        chk({tag, "_done"}, {done3, done1}, 0);
    endtask

    typedef struct {
        bit s, a, r;
        bit busy, rd;
        int addr;
        bit v;
        int idx;
        logic [31:0] k;
        bit done;
    } vec_t;

    vec_t tbl [13];

    initial begin
        bit found;

        tbl[0]  = '{1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0};
        tbl[1]  = '{0, 0, 1, 1, 1, 0, 0, 0, 32'h0, 0};
        tbl[2]  = '{1, 0, 1, 1, 1, 1, 1, 0, word(0), 0};
        tbl[3]  = '{0, 0, 1, 1, 1, 2, 1, 1, word(1), 0};
        tbl[4]  = '{0, 0, 0, 1, 1, 3, 1, 2, word(2), 0};
        tbl[5]  = '{0, 0, 0, 1, 1, 4, 1, 2, word(2), 0};
        tbl[6]  = '{1, 1, 1, 1, 1, 5, 1, 2, word(2), 0};
        tbl[7]  = '{1, 1, 1, 0, 0, 0, 0, 0, 32'h0, 0};
        tbl[8]  = '{1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0};
        tbl[9]  = '{0, 0, 1, 1, 1, 0, 0, 0, 32'h0, 0};
        tbl[10] = '{0, 0, 1, 1, 1, 1, 1, 0, word(0), 0};
        tbl[11] = '{0, 1, 1, 1, 1, 2, 1, 1, word(1), 0};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0};

        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b0;
        for (int m = 0; m < 2; m++) m_reset(m);
        clr_track();
        repeat (2) @(negedge clock);
        #1;
        chk_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            start = tbl[i].s;
            abort = tbl[i].a;
            ready = tbl[i].r;
            #1;
            chk($sformatf("tbl%0d_busy", i), busy1, tbl[i].busy);
            chk($sformatf("tbl%0d_rd_en", i), rd1, tbl[i].rd);
            chk($sformatf("tbl%0d_addr", i), addr1, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), rv1, tbl[i].v);
            chk($sformatf("tbl%0d_index", i), ri1, tbl[i].idx);
            if (tbl[i].v) chk($sformatf("tbl%0d_k", i), rk1, tbl[i].k);
            chk($sformatf("tbl%0d_done", i), done1, tbl[i].done);
            step(tbl[i].s, tbl[i].a, tbl[i].r);
        end

        settle();
        clr_track();
        cyc = 0;
        step(1'b1, 1'b0, 1'b1);
        repeat (80) step(1'b0, 1'b0, 1'b1);
        chk("stream_first_valid_ml1", first_valid[0], 2);
        chk("stream_first_valid_ml3", first_valid[1], 4);
        chk("stream_done_cycle_ml1", done_cyc[0], 66);
        chk("stream_done_cycle_ml3", done_cyc[1], 68);
        chk("stream_valid_count_ml1", valid_cnt[0], K);
        chk("stream_valid_count_ml3", valid_cnt[1], K);

        settle();
        clr_track();
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, i % 2 == 0);
        chk("toggle_done_ml1", done_seen[0], 1);
        chk("toggle_done_ml3", done_seen[1], 1);

        settle();
        clr_track();
        cyc = 0;
        step(1'b1, 1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b0, 1'b0);
        chk("stall_reads_ml1", rd_cnt[0], D);
        chk("stall_reads_ml3", rd_cnt[1], D);
        chk("stall_k_ml1", rk1, word(0));
        chk("stall_k_ml3", rk3, word(0));
        chk("stall_index", {ri3, ri1}, 0);
        repeat (80) step(1'b0, 1'b0, 1'b1);
        chk("stall_done_ml1", done_seen[0], 1);
        chk("stall_done_ml3", done_seen[1], 1);

        settle();
        clr_track();
        step(1'b1, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            #1;
            if (rv1 && ri1 == 6'd30) found = 1'b1;
            else step(1'b0, 1'b0, 1'b1);
        end
        chk("abort_reached_30", found, 1);
        step(1'b0, 1'b1, 1'b1);
        #1;
        chk("abort_busy", {busy3, busy1}, 0);
        chk("abort_valid", {rv3, rv1}, 0);
        clr_track();
        repeat (10) step(1'b0, 1'b0, 1'b1);
        chk("abort_no_done", {done_seen[1], done_seen[0]}, 0);
        step(1'b1, 1'b0, 1'b1);
        #1;
        chk("restart_rd_en", {rd3, rd1}, 2'b11);
        chk("restart_addr", {addr3, addr1}, 0);
        chk("restart_index", {ri3, ri1}, 0);
        repeat (10) step(1'b0, 1'b0, 1'b1);

        reset_n = 1'b0;
        #1;
        chk_zero("async_reset");
        for (int m = 0; m < 2; m++) m_reset(m);
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
